trng_ehr_collector: RTL and testbench



---
 rtl/trng_ehr_collector.sv | 161 ++++++++++++++++
 tb/tb_trng_ehr_collector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_ehr_collector.sv
//------------------------------------------------------------------------------
// trng_ehr_collector
//
// Collects debiased entropy bits from the balance filter into an entropy
// holding register (EHR) of EHR_WORDS x WORD_W bits, LSB first. When every
// bit has been collected, the block enters FULL. In FULL it holds its contents
// until the host reads the last word (the drain read). The drain read returns
// that word and re-arms the collector for a fresh fill.
//
// Ports
//   rng_clk               in   sole clock, rising edge
//   rst_trng_logic        in   synchronous active-high reset
//   rnd_src_en            in   entropy source enable; low aborts a partial fill
//   balance_filter_valid  in   one-cycle strobe qualifying balance_filter_data
//   balance_filter_data   in   debiased entropy bit
//   ehr_rd_req            in   one-cycle word read request
//   ehr_rd_addr   [2:0]   in   EHR word index for the read
//   ehr_rd_ack            out  read completion strobe, one cycle after request
//   ehr_rd_data   [W-1:0] out  registered read data, valid with ehr_rd_ack
//   ehr_valid             out  high while the EHR is completely filled
//   ehr_bit_cnt   [7:0]   out  number of bits collected so far
//   ehr_overflow          out  sticky: a bit arrived and was dropped while FULL
//   ehr_state_dbg [1:0]   out  raw FSM state, for observation only
//
// Handshake: ehr_rd_req is a single-cycle request that is always accepted.
// The read is acknowledged by ehr_rd_ack exactly one cycle later, and
// ehr_rd_data is valid in that same cycle. Requests on consecutive cycles
// produce acks on consecutive cycles, in order. No back-pressure exists.
//------------------------------------------------------------------------------
module trng_ehr_collector #(
    parameter int EHR_WORDS = 6,
    parameter int WORD_W    = 32
) (
    input  logic              rng_clk,
    input  logic              rst_trng_logic,
    input  logic              rnd_src_en,
    input  logic              balance_filter_valid,
    input  logic              balance_filter_data,
    input  logic              ehr_rd_req,
    input  logic [2:0]        ehr_rd_addr,
    output logic              ehr_rd_ack,
    output logic [WORD_W-1:0] ehr_rd_data,
    output logic              ehr_valid,
    output logic [7:0]        ehr_bit_cnt,
    output logic              ehr_overflow,
    output logic [1:0]        ehr_state_dbg
);

    // The 8-bit counter must reach TOTAL_BITS, so TOTAL_BITS cannot exceed 255.
    localparam int TOTAL_BITS = EHR_WORDS * WORD_W;

    // One-hot encoding leaves 2'b00 and 2'b11 as illegal states. The default
    // branch of the FSM recovers from them.
    typedef enum logic [1:0] {
        ST_FILL = 2'b01,
        ST_FULL = 2'b10
    } state_t;

    state_t                state;
    logic [TOTAL_BITS-1:0] ehr_q;

    logic [TOTAL_BITS-1:0] bit_mask;
    logic [TOTAL_BITS-1:0] store_mask;
    logic                  last_bit;
    logic                  addr_in_range;
    logic                  drain_rd;
    logic [WORD_W-1:0]     rd_words [8];
    logic [WORD_W-1:0]     rd_word_sel;

    assign ehr_state_dbg = state;

    // Unfilled positions are always zero, so a new bit only needs to be ORed
    // in at the position selected by the counter.
    assign bit_mask   = TOTAL_BITS'(1) << ehr_bit_cnt;
    assign store_mask = balance_filter_data ? bit_mask : '0;
    assign last_bit   = (ehr_bit_cnt == 8'(TOTAL_BITS - 1));

    assign addr_in_range = (int'(ehr_rd_addr) < EHR_WORDS);
    assign drain_rd      = ehr_rd_req && (state == ST_FULL) &&
                           (ehr_rd_addr == 3'(EHR_WORDS - 1));

    // The word view covers the full 3-bit address space. Addresses beyond
    // EHR_WORDS read as zero, so the read mux needs no out-of-range special case.
    for (genvar g = 0; g < 8; g++) begin : g_words
        if (g < EHR_WORDS) begin : g_real
            assign rd_words[g] = ehr_q[g*WORD_W +: WORD_W];
        end else begin : g_pad
            assign rd_words[g] = '0;
        end
    end

    // Contents are only exposed once the register is complete. A read while
    // filling returns zero, so a partial fill cannot leak out.
    always_comb begin
        rd_word_sel = '0;
        if ((state == ST_FULL) && addr_in_range) begin
            rd_word_sel = rd_words[ehr_rd_addr];
        end
    end

    always_ff @(posedge rng_clk) begin
        if (rst_trng_logic) begin
            state        <= ST_FILL;
            ehr_q        <= '0;
            ehr_bit_cnt  <= 8'd0;
            ehr_valid    <= 1'b0;
            ehr_overflow <= 1'b0;
            ehr_rd_ack   <= 1'b0;
            ehr_rd_data  <= '0;
        end else begin
            // Read port: every request is acknowledged on the next cycle. The
            // data is sampled from the pre-edge state, so the drain read still
            // returns the last word before the clear takes effect.
            ehr_rd_ack <= ehr_rd_req;
            if (ehr_rd_req) begin
                ehr_rd_data <= rd_word_sel;
            end

            case (state)
                ST_FILL: begin
                    if (!rnd_src_en) begin
                        // Source disabled: discard the partial fill.
                        ehr_q       <= '0;
                        ehr_bit_cnt <= 8'd0;
                    end else if (balance_filter_valid) begin
                        ehr_q       <= ehr_q | store_mask;
                        ehr_bit_cnt <= ehr_bit_cnt + 8'd1;
                        if (last_bit) begin
                            state     <= ST_FULL;
                            ehr_valid <= 1'b1;
                        end
                    end
                end

                ST_FULL: begin
                    if (drain_rd) begin
                        // The drain read re-arms the collector. A bit arriving
                        // in this same cycle is dropped, and it does not count
                        // as an overflow.
                        state        <= ST_FILL;
                        ehr_q        <= '0;
                        ehr_bit_cnt  <= 8'd0;
                        ehr_valid    <= 1'b0;
                        ehr_overflow <= 1'b0;
                    end else if (balance_filter_valid) begin
                        ehr_overflow <= 1'b1;
                    end
                end

                default: begin
                    state        <= ST_FILL;
                    ehr_q        <= '0;
                    ehr_bit_cnt  <= 8'd0;
                    ehr_valid    <= 1'b0;
                    ehr_overflow <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_ehr_collector.sv
//------------------------------------------------------------------------------
// tb_trng_ehr_collector
//
// Randomized and directed stimulus for trng_ehr_collector. A behavioural
// reference model tracks the collected bits as a queue, and expected read data
// flows through exp_q. The bench prints one summary line at the end.
//------------------------------------------------------------------------------
module tb_trng_ehr_collector;

    localparam int NW    = 6;
    localparam int WW    = 32;
    localparam int TOTAL = NW * WW;

    // ---------------- clock / reset ----------------
    logic rng_clk = 1'b0;
    always #5 rng_clk = ~rng_clk;

    logic          rst_trng_logic;
    logic          rnd_src_en;
    logic          balance_filter_valid;
    logic          balance_filter_data;
    logic          ehr_rd_req;
    logic [2:0]    ehr_rd_addr;
    logic          ehr_rd_ack;
    logic [WW-1:0] ehr_rd_data;
    logic          ehr_valid;
    logic [7:0]    ehr_bit_cnt;
    logic          ehr_overflow;
    logic [1:0]    ehr_state_dbg;

    trng_ehr_collector #(.EHR_WORDS(NW), .WORD_W(WW)) dut (
        .rng_clk              (rng_clk),
        .rst_trng_logic       (rst_trng_logic),
        .rnd_src_en           (rnd_src_en),
        .balance_filter_valid (balance_filter_valid),
        .balance_filter_data  (balance_filter_data),
        .ehr_rd_req           (ehr_rd_req),
        .ehr_rd_addr          (ehr_rd_addr),
        .ehr_rd_ack           (ehr_rd_ack),
        .ehr_rd_data          (ehr_rd_data),
        .ehr_valid            (ehr_valid),
        .ehr_bit_cnt          (ehr_bit_cnt),
        .ehr_overflow         (ehr_overflow),
        .ehr_state_dbg        (ehr_state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    bit            m_bits[$];   // collected bits, index = bit position
    bit            m_full;
    bit            m_ovf;
    bit            exp_ack;
    logic [WW-1:0] exp_q[$];    // expected read data, in request order

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] m_word(input int w);
        logic [WW-1:0] r;
        r = '0;
        for (int j = 0; j < WW; j++) begin
            if (w * WW + j < m_bits.size()) r[j] = m_bits[w * WW + j];
        end
        return r;
    endfunction

    // Applies one clock edge's worth of inputs to the reference model.
    task automatic model_edge(input bit rst, input bit en, input bit v, input bit d,
                              input bit req, input logic [2:0] addr);
        if (rst) begin
            m_bits.delete();
            m_full  = 1'b0;
            m_ovf   = 1'b0;
            exp_ack = 1'b0;
            exp_q.delete();
        end else begin
            exp_ack = req;
            if (req) exp_q.push_back((m_full && int'(addr) < NW) ? m_word(int'(addr)) : '0);
            if (m_full) begin
                if (req && int'(addr) == NW - 1) begin
                    m_bits.delete();
                    m_full = 1'b0;
                    m_ovf  = 1'b0;
                end else if (v) begin
                    m_ovf = 1'b1;
                end
            end else if (!en) begin
                m_bits.delete();
            end else if (v) begin
                m_bits.push_back(d);
                if (m_bits.size() == TOTAL) m_full = 1'b1;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit en, input bit v, input bit d,
                        input bit req, input logic [2:0] addr);
        rst_trng_logic       = rst;
        rnd_src_en           = en;
        balance_filter_valid = v;
        balance_filter_data  = d;
        ehr_rd_req           = req;
        ehr_rd_addr          = addr;
        @(posedge rng_clk);
        #1;
        model_edge(rst, en, v, d, req, addr);
        check("ehr_valid", 32'(ehr_valid), 32'(m_full));
        check("ehr_bit_cnt", 32'(ehr_bit_cnt), 32'(m_bits.size()));
        check("ehr_overflow", 32'(ehr_overflow), 32'(m_ovf));
        check("ehr_rd_ack", 32'(ehr_rd_ack), 32'(exp_ack));
        if (rst) check("rd_data_rst", ehr_rd_data, 32'h0);
        if (exp_ack && exp_q.size() > 0) check("ehr_rd_data", ehr_rd_data, exp_q.pop_front());
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic rd(input int a);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'(a));
    endtask

    task automatic fill_rand(input int n);
        int sent = 0;
        while (sent < n) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            step(1'b0, 1'b1, v, 1'($urandom_range(0, 1)), 1'b0, 3'd0);
            if (v) sent++;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_trng_logic       = 1'b1;
        rnd_src_en           = 1'b0;
        balance_filter_valid = 1'b0;
        balance_filter_data  = 1'b0;
        ehr_rd_req           = 1'b0;
        ehr_rd_addr          = 3'd0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
        check("rst_cnt_const", 32'(ehr_bit_cnt), 32'd0);

        // Alternating-pattern fill: bit i = i%2
        for (int i = 0; i < TOTAL; i++) step(1'b0, 1'b1, 1'b1, 1'(i % 2), 1'b0, 3'd0);
        check("full_valid_const", 32'(ehr_valid), 32'd1);
        check("full_cnt_const", 32'(ehr_bit_cnt), 32'd192);
        for (int w = 0; w < NW - 1; w++) begin
            rd(w);
            check("pattern_word", ehr_rd_data, 32'hAAAAAAAA);
        end

        // Overflow in FULL; contents unchanged
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        check("overflow_const", 32'(ehr_overflow), 32'd1);
        rd(0);
        check("word0_after_ovf", ehr_rd_data, 32'hAAAAAAAA);

        // Bad reads in FULL; enable low has no effect in FULL
        rd(7);
        rd(6);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Drain read with a bit arriving in the same cycle
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
        check("drain_data_const", ehr_rd_data, 32'hAAAAAAAA);
        check("drain_ovf_const", 32'(ehr_overflow), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        check("first_bit_cnt", 32'(ehr_bit_cnt), 32'd1);
        rd(0);                       // read in FILL returns 0
        fill_rand(TOTAL - 1);
        rd(0);
        check("word0_bit0", 32'(ehr_rd_data[0]), 32'd1);
        rd(NW - 1);                  // drain

        // Abort after 50 bits, then refill with new data
        fill_rand(50);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        check("abort_cnt_const", 32'(ehr_bit_cnt), 32'd0);
        fill_rand(TOTAL);
        for (int w = 0; w < NW; w++) rd(w);
        for (int k = 0; k < 4; k++) rd(k);  // now in FILL after drain

        // Randomized traffic, including back-to-back reads and rare resets
        for (int c = 0; c < 4000; c++) begin
            step(1'($urandom_range(0, 499) == 0),
                 1'($urandom_range(0, 999) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 5) == 0),
                 3'($urandom_range(0, 7)));
        end

        // Reset mid-fill at bit 100 with a read issued in the reset cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        fill_rand(100);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
        idle();
        check("rd_ack_after_rst", 32'(ehr_rd_ack), 32'd0);
        check("cnt_after_rst", 32'(ehr_bit_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
